// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth partial-product accumulator.
// Optional pp_last checking is enabled by defining BOOTH_ACC_LAST_CHK_EN.
package booth_pkg;

  localparam int unsigned DEF_ROWS   = 8;
  localparam int unsigned DEF_PP_W   = 17;
  localparam int unsigned DEF_PROD_W = 32;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  // Width of a row counter able to hold 0..rows-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/booth_row_align.sv
// Combinational alignment of one Booth row: sign-extend, apply the +1
// correction for negative rows, then shift left by two bits per row index.
module booth_row_align
  import booth_pkg::*;
#(
  parameter int unsigned PP_W   = DEF_PP_W,
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned K_W    = cnt_w(DEF_ROWS)
) (
  input  logic [PP_W-1:0]   i_pp,
  input  logic              i_pp_neg,
  input  logic [K_W-1:0]    i_k,
  output logic [PROD_W-1:0] o_addend_c
);

  logic [PROD_W-1:0] w_ext;
  logic [PROD_W-1:0] w_row;
  logic [K_W:0]      w_shamt;

  assign w_ext      = PROD_W'($signed(i_pp));
  assign w_row      = w_ext + PROD_W'(i_pp_neg);
  assign w_shamt    = {i_k, 1'b0};
  assign o_addend_c = w_row << w_shamt;

endmodule

// File: rtl/booth_pp_accum.sv
// Accumulates ROWS Booth partial-product rows into a PROD_W-bit product with
// a valid/ready handshake on both sides. Define BOOTH_ACC_LAST_CHK_EN to add
// the pp_last input and the sticky err output.
module booth_pp_accum
  import booth_pkg::*;
#(
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned PP_W   = DEF_PP_W,
  parameter int unsigned PROD_W = DEF_PROD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pp_valid,
  output logic              pp_ready,
  input  logic [PP_W-1:0]   pp,
  input  logic              pp_neg,
`ifdef BOOTH_ACC_LAST_CHK_EN
  input  logic              pp_last,
  output logic              err,
`endif
  output logic              prod_valid,
  input  logic              prod_ready,
  output logic [PROD_W-1:0] prod
);

  localparam int unsigned    K_W    = cnt_w(ROWS);
  localparam logic [K_W-1:0] K_LAST = K_W'(ROWS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [K_W-1:0]    r_k;
  logic [PROD_W-1:0] r_acc;
  logic [PROD_W-1:0] w_addend;
  logic              w_accept;
  logic              w_last;
  logic              w_consume;

  assign w_accept  = pp_valid && pp_ready;
  assign w_last    = (r_k == K_LAST);
  assign w_consume = (r_state == ST_DONE) && prod_ready;

  booth_row_align #(
    .PP_W   (PP_W),
    .PROD_W (PROD_W),
    .K_W    (K_W)
  ) u_align (
    .i_pp       (pp),
    .i_pp_neg   (pp_neg),
    .i_k        (r_k),
    .o_addend_c (w_addend)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACC: begin
        if (w_accept && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (prod_ready) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    pp_ready   = 1'b0;
    prod_valid = 1'b0;
    case (r_state)
      ST_ACC:  pp_ready   = 1'b1;
      ST_DONE: prod_valid = 1'b1;
      default: pp_ready   = 1'b0;
    endcase
  end

  // Row counter and accumulator; a stalled producer simply leaves both held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (w_consume) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (w_accept) begin
      r_k   <= w_last ? '0 : r_k + K_W'(1);
      r_acc <= r_acc + w_addend;
    end
  end

  assign prod = r_acc;

`ifdef BOOTH_ACC_LAST_CHK_EN
  logic r_err;

  // Sticky flag: pp_last must mark exactly the final row of each product.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_accept && (pp_last != w_last)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_booth_pp_accum.sv
// Self-checking bench for booth_pp_accum: directed corner products plus
// randomized rows with stalls, against an arithmetic product model.
module tb_booth_pp_accum;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned PP_W   = 17;
  localparam int unsigned PROD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              pp_valid;
  logic              pp_ready;
  logic [PP_W-1:0]   pp;
  logic              pp_neg;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] prod;
`ifdef BOOTH_ACC_LAST_CHK_EN
  logic              pp_last;
  logic              err;
  logic              err_exp;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [PP_W-1:0] rp [ROWS];
  logic            rn [ROWS];
  logic            rl [ROWS];

  always #5 clk = ~clk;

  booth_pp_accum #(
    .ROWS   (ROWS),
    .PP_W   (PP_W),
    .PROD_W (PROD_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp         (pp),
    .pp_neg     (pp_neg),
`ifdef BOOTH_ACC_LAST_CHK_EN
    .pp_last    (pp_last),
    .err        (err),
`endif
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod       (prod)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Product = sum over rows of (signed row value + correction) * 4^k, mod 2^32.
  function automatic logic [31:0] ref_prod();
    longint s = 0;
    for (int k = 0; k < ROWS; k++) begin
      s += (longint'($signed(rp[k])) + longint'(rn[k])) * (longint'(1) << (2 * k));
    end
    return 32'(s);
  endfunction

  task automatic clear_rows();
    for (int k = 0; k < ROWS; k++) begin
      rp[k] = '0;
      rn[k] = 1'b0;
      rl[k] = (k == ROWS - 1);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pp_valid   = 1'b0;
    prod_ready = 1'b0;
    pp         = '0;
    pp_neg     = 1'b0;
`ifdef BOOTH_ACC_LAST_CHK_EN
    pp_last    = 1'b0;
    err_exp    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pp_ready", 32'(pp_ready), 32'd1);
    chk("rst_prod_valid", 32'(prod_valid), 32'd0);
    chk("rst_prod", prod, 32'd0);
`ifdef BOOTH_ACC_LAST_CHK_EN
    chk("rst_err", 32'(err), 32'd0);
`endif
  endtask

  // Present row k after `gap` idle cycles carrying junk data.
  task automatic give_row(input int k, input int gap);
    int b;
    for (int g = 0; g < gap; g++) begin
      pp_valid = 1'b0;
      pp       = PP_W'($urandom);
      pp_neg   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    pp       = rp[k];
    pp_neg   = rn[k];
`ifdef BOOTH_ACC_LAST_CHK_EN
    pp_last  = rl[k];
`endif
    pp_valid = 1'b1;
    b = 0;
    while (!pp_ready && b < 20) begin
      @(posedge clk);
      #1;
      b++;
    end
    chk("row_pp_ready", 32'(pp_ready), 32'd1);
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
`ifdef BOOTH_ACC_LAST_CHK_EN
    if (rl[k] != (k == ROWS - 1)) err_exp = 1'b1;
    chk("err_after_row", 32'(err), 32'(err_exp));
`endif
  endtask

  // Feed all rows, check the product, hold it `hold` cycles, then consume.
  task automatic do_product(input string tag, input int max_gap, input int hold);
    logic [31:0] exp;
    exp = ref_prod();
    for (int k = 0; k < ROWS; k++) begin
      give_row(k, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
    chk({tag, "_prod"}, prod, exp);
    chk({tag, "_prod_valid"}, 32'(prod_valid), 32'd1);
    chk({tag, "_pp_ready_done"}, 32'(pp_ready), 32'd0);
    // Junk rows offered while DONE, including the consume cycle, must be ignored.
    pp_valid = 1'b1;
    pp       = PP_W'($urandom);
    pp_neg   = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_prod"}, prod, exp);
      chk({tag, "_hold_valid"}, 32'(prod_valid), 32'd1);
      chk({tag, "_hold_pp_ready"}, 32'(pp_ready), 32'd0);
    end
    prod_ready = 1'b1;
    @(posedge clk);
    #1;
    prod_ready = 1'b0;
    pp_valid   = 1'b0;
    chk({tag, "_consumed_valid"}, 32'(prod_valid), 32'd0);
    chk({tag, "_consumed_pp_ready"}, 32'(pp_ready), 32'd1);
  endtask

  initial begin
    do_reset();

    // Single LSB row
    clear_rows();
    rp[0] = 17'h00001;
    do_product("lsb", 0, 0);
    chk("lsb_ref", ref_prod(), 32'h00000001);

    // Negative row with correction gives -1
    clear_rows();
    rp[0] = 17'h1FFFE; rn[0] = 1'b1;
    do_product("neg_one", 0, 0);

    // Top row alignment, positive then sign-extended negative
    clear_rows();
    rp[7] = 17'h00001;
    do_product("row7_pos", 0, 0);
    clear_rows();
    rp[7] = 17'h1FFFF;
    do_product("row7_neg", 0, 0);

    // Consumer back-pressure for three cycles
    clear_rows();
    rp[2] = 17'h0ABCD; rn[2] = 1'b1; rp[5] = 17'h12345;
    do_product("hold3", 0, 3);

    // Reset after four rows discards them
    clear_rows();
    for (int k = 0; k < 4; k++) rp[k] = 17'h1F0F0;
    for (int k = 0; k < 4; k++) give_row(k, 0);
    do_reset();
    clear_rows();
    rp[0] = 17'h00003;
    do_product("after_rst", 0, 0);
    clear_rows();
    do_product("no_residue", 0, 0);

`ifdef BOOTH_ACC_LAST_CHK_EN
    // Early pp_last sets err stickily without disturbing the product
    clear_rows();
    rp[1] = 17'h00F00; rp[6] = 17'h1C001; rn[6] = 1'b1;
    rl[5] = 1'b1;
    do_product("last_chk", 0, 1);
    chk("err_sticky", 32'(err), 32'd1);
    clear_rows();
    rp[0] = 17'h00007;
    do_product("err_no_effect", 1, 0);
    chk("err_still_set", 32'(err), 32'd1);
    do_reset();
`endif

    // Random rows with producer stalls and consumer back-pressure
    for (int p = 0; p < 20; p++) begin
      for (int k = 0; k < ROWS; k++) begin
        rp[k] = PP_W'($urandom);
        rn[k] = 1'($urandom);
        rl[k] = (k == ROWS - 1);
      end
      do_product("rand", 3, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_pp_accum.md
BOOTH_PP_ACCUM -- requirements
Module: booth_pp_accum

Interface
REQ-001 The block SHALL have parameter ROWS, default 8, meaning partial-product rows per product.
REQ-002 The block SHALL have parameter PP_W, default 17, meaning partial-product row width.
REQ-003 The block SHALL have parameter PROD_W, default 32, meaning accumulated product width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-006 The block SHALL have port pp_valid, input, 1, meaning a row is presented.
REQ-007 The block SHALL have port pp_ready, output, 1, meaning the block accepts a row this cycle.
REQ-008 The block SHALL have port pp, input, PP_W, meaning the Booth row: complemented when negative, not yet incremented.
REQ-009 The block SHALL have port pp_neg, input, 1, meaning a +1 correction at the row LSB.
REQ-010 The block SHALL have port prod_valid, output, 1, meaning the product is available.
REQ-011 The block SHALL have port prod_ready, input, 1, meaning the consumer takes the product.
REQ-012 The block SHALL have port prod, output, PROD_W, meaning the two's-complement product.

Function
REQ-013 A row SHALL be accepted in a cycle only when pp_valid and pp_ready are both 1.
REQ-014 Row index k SHALL be an internal counter 0..ROWS-1, incremented per accepted row.
REQ-015 Row k SHALL contribute (sign_extend(pp) + pp_neg) << 2k, summed modulo 2^PROD_W.
REQ-016 Sign extension SHALL replicate pp[PP_W-1] up to PROD_W bits before the shift.
REQ-017 The FSM SHALL have states ACC and DONE.
REQ-018 In ACC, pp_ready SHALL be 1 and prod_valid SHALL be 0.
REQ-019 In DONE, pp_ready SHALL be 0 and prod_valid SHALL be 1.
REQ-020 ACC SHALL go to DONE on acceptance of row ROWS-1, with prod valid the next cycle (latency 1 cycle after the last row).
REQ-021 In DONE, prod SHALL hold stable while prod_ready is 0.
REQ-022 DONE SHALL go to ACC with the accumulator and counter cleared when prod_ready is 1.
REQ-023 In DONE with prod_ready 1, a row presented in that cycle SHALL NOT be accepted; it is accepted on the following cycle at the earliest.
REQ-024 pp_valid deasserted mid-product SHALL stall: counter and accumulator are held, with no timeout.

Reset
REQ-025 While rst is 1, the block SHALL go to ACC, set counter to 0, accumulator and prod to 0, prod_valid to 0, and pp_ready to 1 on the first cycle after rst deasserts.
REQ-026 Reset mid-product or in DONE SHALL discard partial results; the next accepted row is row 0.

Configuration
REQ-027 With BOOTH_ACC_LAST_CHK_EN defined, the block SHALL add input pp_last (1 bit) and output err (1 bit).
REQ-028 With BOOTH_ACC_LAST_CHK_EN defined, err SHALL set sticky when an accepted row has pp_last not equal to (k==ROWS-1), and clear only on rst.
REQ-029 With BOOTH_ACC_LAST_CHK_EN defined, err SHALL NOT alter accumulation or state transitions.
REQ-030 Without BOOTH_ACC_LAST_CHK_EN, the pp_last and err ports SHALL be absent and there SHALL be no check logic.

Structure
REQ-031 Shared package booth_pkg SHALL hold default PP_W/PROD_W/ROWS constants and the ACC/DONE state enum typedef.
REQ-032 Sub-module booth_row_align SHALL be purely combinational: pp, pp_neg, k in; aligned PROD_W-bit addend out.
REQ-033 The accumulator adder and FSM SHALL reside in booth_pp_accum.

Verification
REQ-034 Bench SHALL cover: rows row0 pp=0x00001 neg=0, rows 1..7 pp=0 neg=0, prod_ready=1 -> prod=0x00000001, prod_valid for exactly 1 cycle.
REQ-035 Bench SHALL cover: row0 pp=0x1FFFE neg=1, rest zero -> prod=0xFFFFFFFF.
REQ-036 Bench SHALL cover: row7 pp=0x00001 neg=0, rest zero -> prod=0x00004000; row7 pp=0x1FFFF neg=0 -> prod=0xFFFFC000.
REQ-037 Bench SHALL cover: prod_ready held 0 for 3 cycles in DONE -> prod stable, pp_ready=0, prod_valid=1; product consumed on cycle 4.
REQ-038 Bench SHALL cover: rst pulsed after 4 rows, then 8 rows with row0 pp=0x00003 -> prod=0x00000003, no residue.
REQ-039 Bench SHALL cover: with BOOTH_ACC_LAST_CHK_EN defined, pp_last=1 on row 5 -> err=1 next cycle and held, prod still correct.
